score_packer: RTL and testbench
===============================

SCORE_PACKER -- requirements
Module: score_packer

Interface
REQ-001 Parameter NUM_CLASSES, default 10: score slots per frame.
REQ-002 Parameter IN_W, default 32: signed width of each incoming accumulator score.
REQ-003 Parameter OUT_W, default 16: signed width of each packed score.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 s_valid  input  1  incoming score beat valid.
REQ-007 s_ready  output  1  packer can accept a beat.
REQ-008 s_data  input  IN_W  signed score for the current class.
REQ-009 s_last  input  1  beat is the final class of a frame.
REQ-010 vec_valid  output  1  packed score vector complete and stable; drives the argmax stage enable.
REQ-011 vec_ready  input  1  downstream consumed the vector.
REQ-012 score_vec  output  NUM_CLASSES*OUT_W  packed signed scores; class k occupies bits [OUT_W*k+OUT_W-1 : OUT_W*k].
REQ-013 frame_err  output  1  sticky framing-error flag.

Function
REQ-014 FSM states: COLLECT and HOLD; the reset state is COLLECT with slot counter cnt=0.
REQ-015 In COLLECT, s_ready SHALL be 1; in HOLD, s_ready SHALL be 0.
REQ-016 A beat is accepted when s_valid and s_ready are both 1; the converted s_data is written to slot cnt, and cnt increments.
REQ-017 Acceptance with cnt=NUM_CLASSES-1 SHALL move to HOLD, reset cnt to 0, and assert vec_valid on the next cycle (1-cycle latency from the final beat).
REQ-018 In HOLD, vec_valid and score_vec SHALL be held stable until vec_ready=1 is sampled; the same edge returns to COLLECT and deasserts vec_valid.
REQ-019 vec_ready while vec_valid=0 SHALL be ignored.
REQ-020 s_last accepted with cnt<NUM_CLASSES-1: drop the frame (no HOLD), reset cnt to 0, set frame_err; the beat's score is still written to its slot.
REQ-021 Final beat (cnt=NUM_CLASSES-1) accepted with s_last=0: set frame_err; the frame is still presented normally.
REQ-022 frame_err SHALL be cleared only by reset.
REQ-023 Slots not rewritten in a frame SHALL retain their prior values.
REQ-024 Back-to-back beats SHALL be accepted every cycle in COLLECT; there is no bubble between frames beyond the HOLD cycles.

Reset
REQ-025 With rst_n=0 at an edge: state=COLLECT, cnt=0, vec_valid=0, score_vec=0, frame_err=0, regardless of any frame in progress or vector held.
REQ-026 s_ready SHALL be 1 on the first cycle after reset release.

Configuration
REQ-027 Macro SCORE_PACKER_SAT_EN defined: s_data above 2^(OUT_W-1)-1 becomes 2^(OUT_W-1)-1, and s_data below -2^(OUT_W-1) becomes -2^(OUT_W-1); otherwise the value passes unchanged.
REQ-028 Macro undefined: the slot receives s_data[OUT_W-1:0] (two's-complement truncation), with no saturation logic instantiated.

Structure
REQ-029 Shared package holds NUM_CLASSES, OUT_W, the FSM state typedef, and the slot-offset function (OUT_W*k).
REQ-030 Sub-module score_sat (IN_W to OUT_W conversion, honouring SCORE_PACKER_SAT_EN) is instantiated once on the s_data path.

Verification
REQ-031 Ten beats 0..9 with values 10*k, s_last on the 10th, vec_ready=1: vec_valid is high for exactly one cycle, 1 cycle after the 10th beat, and slot k=10*k; frame_err=0.
REQ-032 Complete frame with vec_ready held 0 for 5 cycles: s_ready=0, and vec_valid and score_vec stay constant through all 5 cycles; release vec_ready, then s_ready=1 on the next cycle.
REQ-033 s_data=100000 and -100000: with SCORE_PACKER_SAT_EN, slots are 32767 and -32768; without it, slots are 0x86A0 and 0x7960.
REQ-034 s_last on the 4th beat: vec_valid never asserts, frame_err=1, and the following 10-beat frame is presented correctly.
REQ-035 rst_n=0 asserted after 6 beats, then a full frame sent: vec_valid asserts only after the 10th post-reset beat, and the score_vec slots not written are 0.

Source files
------------

// File: rtl/score_packer_pkg.sv
// score_packer_pkg: shared constants, FSM state type and slot-offset helper for score_packer.
package score_packer_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int OUT_W = 16;
  typedef enum logic {COLLECT, HOLD} state_t;
  function automatic int slot_off(input int k, input int w = OUT_W);
    return w * k;
  endfunction
endpackage

// File: rtl/score_sat.sv
// score_sat: converts one signed IN_W score to OUT_W (saturating under SCORE_PACKER_SAT_EN, else truncating).
// Ports: d_i signed input score, q_o converted score.
module score_sat #(
  parameter int IN_W = 32,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  d_i,
  output logic        [OUT_W-1:0] q_o
);
`ifdef SCORE_PACKER_SAT_EN
  localparam logic signed [IN_W-1:0] MAXV = IN_W'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] MINV = -MAXV - 1;
  assign q_o = d_i > MAXV ? MAXV[OUT_W-1:0] : d_i < MINV ? MINV[OUT_W-1:0] : d_i[OUT_W-1:0];
`else
  // Upper bits are deliberately discarded by two's-complement truncation.
  logic unused_hi;
  assign unused_hi = ^d_i[IN_W-1:OUT_W];
  assign q_o = d_i[OUT_W-1:0];
`endif
endmodule

// File: rtl/score_packer.sv
// score_packer: collects NUM_CLASSES score beats into a packed vector held until consumed.
// Ports: clk/rst_n (sync active-low), s_valid/s_ready/s_data/s_last score stream in,
// vec_valid/vec_ready/score_vec packed vector out, frame_err sticky framing error.
// Option: SCORE_PACKER_SAT_EN selects saturating instead of truncating conversion.
module score_packer #(
  parameter int NUM_CLASSES = score_packer_pkg::NUM_CLASSES,
  parameter int IN_W = 32,
  parameter int OUT_W = score_packer_pkg::OUT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [IN_W-1:0]              s_data,
  input  logic                         s_last,
  output logic                         vec_valid,
  input  logic                         vec_ready,
  output logic [NUM_CLASSES*OUT_W-1:0] score_vec,
  output logic                         frame_err
);
  import score_packer_pkg::*;
  localparam int CW = NUM_CLASSES > 1 ? $clog2(NUM_CLASSES) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_CLASSES*OUT_W-1:0] vec_q, vec_d;
  logic err_q, err_d;
  logic [OUT_W-1:0] conv;
  logic acc, fin;
  score_sat #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat (.d_i(s_data), .q_o(conv));
  assign s_ready = state_q == COLLECT;
  assign acc = s_valid & s_ready;
  assign fin = cnt_q == CW'(NUM_CLASSES - 1);
  always_comb begin
    vec_d = vec_q;
    for (int k = 0; k < NUM_CLASSES; k++)
      if (acc && cnt_q == CW'(k)) vec_d[slot_off(k, OUT_W) +: OUT_W] = conv;
    cnt_d = acc ? ((fin || s_last) ? '0 : cnt_q + 1'b1) : cnt_q;
    // A framing error is a final slot without s_last, or s_last before the final slot.
    err_d = err_q | (acc & (fin ^ s_last));
    state_d = (acc && fin) ? HOLD : (state_q == HOLD && vec_ready) ? COLLECT : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q <= '0;
      vec_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      vec_q <= vec_d;
      err_q <= err_d;
    end
  end
  assign vec_valid = state_q == HOLD;
  assign score_vec = vec_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_score_packer.sv
// tb_score_packer: scoreboard bench for score_packer with directed frames.
module tb_score_packer;
  localparam int NC = 10;
  localparam int OW = 16;
  localparam int VW = NC * OW;
  logic clk = 0, rst_n = 0, s_valid = 0, s_last = 0, vec_ready = 0;
  logic [31:0] s_data = 0;
  logic s_ready, vec_valid, frame_err;
  logic [VW-1:0] score_vec;
  typedef struct { logic [VW-1:0] v; logic e; } exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  logic [OW-1:0] m_slot [NC];
  int m_cnt = 0;
  logic m_err = 0;

  score_packer dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .vec_valid(vec_valid), .vec_ready(vec_ready), .score_vec(score_vec),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [VW-1:0] a, input logic [VW-1:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic logic [OW-1:0] conv(input int d);
`ifdef SCORE_PACKER_SAT_EN
    if (d > 32767) return 16'h7FFF;
    if (d < -32768) return 16'h8000;
`endif
    return d[OW-1:0];
  endfunction

  function automatic logic [VW-1:0] mvec();
    logic [VW-1:0] r;
    for (int k = 0; k < NC; k++) r[k*OW +: OW] = m_slot[k];
    return r;
  endfunction

  task automatic mclear();
    for (int k = 0; k < NC; k++) m_slot[k] = '0;
    m_cnt = 0;
    m_err = 0;
    q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && vec_valid && vec_ready) begin
      if (q.size() == 0) chk("unexpected_vec", 1, 0);
      else begin
        exp_t x;
        x = q.pop_front();
        chk("vec", score_vec, x.v);
        chk("vec_err", frame_err, x.e);
      end
    end
  end

  task automatic beat(input int d, input logic l);
    int n;
    exp_t x;
    n = 0;
    s_valid = 1;
    s_data = d;
    s_last = l;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("beat_stall", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 0;
    s_last = 0;
    m_slot[m_cnt] = conv(d);
    if (m_cnt == NC - 1) begin
      if (!l) m_err = 1;
      m_cnt = 0;
      x.v = mvec();
      x.e = m_err;
      q.push_back(x);
    end else if (l) begin
      m_cnt = 0;
      m_err = 1;
    end else m_cnt++;
  endtask

  task automatic frame(input int base, input int step, input logic with_last);
    for (int k = 0; k < NC; k++) beat(base + step * k, with_last && k == NC - 1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    mclear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    mclear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_score_vec", score_vec, 0);
    chk("rst_frame_err", frame_err, 0);
    @(posedge clk);
    #1;
    vec_ready = 1;
    frame(0, 10, 1);
    @(negedge clk);
    chk("lat_vec_valid", vec_valid, 1);
    chk("lat_frame_err", frame_err, 0);
    chk("slot9_90", score_vec[159:144], 16'd90);
    chk("slot3_30", score_vec[63:48], 16'd30);
    @(negedge clk);
    chk("vv_one_cycle", vec_valid, 0);
    @(posedge clk);
    #1;
    vec_ready = 0;
    frame(-20, 3, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_s_ready", s_ready, 0);
      chk("hold_vec_valid", vec_valid, 1);
      chk("hold_score_vec", score_vec, mvec());
    end
    @(posedge clk);
    #1;
    vec_ready = 1;
    @(posedge clk);
    #1;
    chk("release_s_ready", s_ready, 1);
    beat(100000, 0);
    beat(-100000, 0);
    for (int k = 2; k < NC; k++) beat(k, k == NC - 1);
    @(negedge clk);
    chk("conv_vec_valid", vec_valid, 1);
`ifdef SCORE_PACKER_SAT_EN
    chk("conv_pos", score_vec[15:0], 16'h7FFF);
    chk("conv_neg", score_vec[31:16], 16'h8000);
`else
    chk("conv_pos", score_vec[15:0], 16'h86A0);
    chk("conv_neg", score_vec[31:16], 16'h7960);
`endif
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) beat(7 * k + 1, k == 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("short_no_vv", vec_valid, 0);
    end
    chk("short_frame_err", frame_err, 1);
    chk("short_retain", score_vec, mvec());
    @(posedge clk);
    #1;
    frame(1000, 1, 1);
    @(negedge clk);
    chk("after_short_vv", vec_valid, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) beat(50 + k, 0);
    do_reset();
    @(negedge clk);
    chk("midrst_vv", vec_valid, 0);
    chk("midrst_score_vec", score_vec, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_s_ready", s_ready, 1);
    for (int k = 0; k < NC - 1; k++) beat(200 + k, 0);
    @(negedge clk);
    chk("midrst_9_no_vv", vec_valid, 0);
    beat(209, 1);
    @(negedge clk);
    chk("midrst_10_vv", vec_valid, 1);
    chk("midrst_err", frame_err, 0);
    @(posedge clk);
    #1;
    do_reset();
    frame(-5000, 1000, 0);
    @(negedge clk);
    chk("nolast_vv", vec_valid, 1);
    chk("nolast_err", frame_err, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
